// File: rtl/cnn_defines_pkg.sv
// Shared CNN pipeline dimensions; the pool1 stage takes its parameter defaults from here.
package cnn_defines;
    localparam int CONV1_OUT_W = 24;
    localparam int CONV1_OUT_H = 24;
    localparam int CONV1_CH    = 6;
    localparam int CNN_FEAT_DW = 16;
    localparam int POOL1_OUT_W = 12;
endpackage

// File: rtl/pool_row_buffer.sv
// One-row store of horizontal 2:1 maxima (all channels per word), written on even rows, read on odd rows.
module pool_row_buffer #(
    parameter int DEPTH = 12,
    parameter int W     = 96,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; even rows always overwrite an entry before an odd row reads it.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Combinational read keeps the pooled result one cycle behind the last window beat.
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pool1_max2x2.sv
// 2x2 stride-2 max-pool with optional ReLU over a raster-order, valid-only multichannel stream.
module pool1_max2x2
    import cnn_defines::*;
#(
    parameter int CH    = CONV1_CH,
    parameter int DW    = CNN_FEAT_DW,
    parameter int IMG_W = CONV1_OUT_W,
    parameter int IMG_H = CONV1_OUT_H,
    parameter bit RELU  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH*DW-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [CH*DW-1:0] out_data,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_last
);
    localparam int PW = CH * DW;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = CW - 1;

    logic [CW-1:0] col_q, col_d, col_eff;
    logic [RW-1:0] row_q, row_d, row_eff;
    logic [PW-1:0] hold_q, hmax, res, rb_rdata;
    logic [PW-1:0] out_data_q;
    logic          out_valid_q, out_sof_q, out_last_q;
    logic          sof_hit, fire, rb_we;

    // A qualified sof overrides the counters so that beat is always pixel (0,0).
    assign sof_hit = in_valid & in_sof;
    assign col_eff = sof_hit ? '0 : col_q;
    assign row_eff = sof_hit ? '0 : row_q;

    // NOTE: defaults first so every path assigns col_d/row_d and no latch is inferred.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (col_eff == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_eff == RW'(IMG_H - 1)) ? '0 : row_eff + 1'b1;
            end else begin
                col_d = col_eff + 1'b1;
                row_d = row_eff;
            end
        end
    end

    assign rb_we = in_valid & ~row_eff[0] & col_eff[0];
    assign fire  = in_valid &  row_eff[0] & col_eff[0];

    pool_row_buffer #(
        .DEPTH (IMG_W / 2),
        .W     (PW),
        .AW    (AW)
    ) u_row_buffer (
        .clk     (clk),
        .we_i    (rb_we),
        .waddr_i (col_eff[CW-1:1]),
        .wdata_i (hmax),
        .raddr_i (col_eff[CW-1:1]),
        .rdata_o (rb_rdata)
    );

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic signed [DW-1:0] hold_s, in_s, buf_s, h_s, p_s;
        assign hold_s = $signed(hold_q[c*DW +: DW]);
        assign in_s   = $signed(in_data[c*DW +: DW]);
        assign buf_s  = $signed(rb_rdata[c*DW +: DW]);
        assign h_s    = (hold_s > in_s) ? hold_s : in_s;
        assign p_s    = (buf_s > h_s) ? buf_s : h_s;
        assign hmax[c*DW +: DW] = h_s;
        assign res[c*DW +: DW]  = (RELU && p_s[DW-1]) ? '0 : p_s;
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            if (in_valid && !col_eff[0]) hold_q <= in_data;
            out_valid_q <= fire;
            out_sof_q   <= fire && (row_eff == RW'(1)) && (col_eff == CW'(1));
            out_last_q  <= fire && (row_eff == RW'(IMG_H - 1)) && (col_eff == CW'(IMG_W - 1));
            if (fire) out_data_q <= res;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_last  = out_last_q;
endmodule

// File: doc/pool1_max2x2.md
Name: pool1_max2x2

Overview:
- 2x2 stride-2 max-pool stage directly downstream of the conv1 stage in the LeNet-style pipeline.
- Consumes the conv1 feature map (24x24, 6 channels in parallel) as a raster-order valid-only stream.
- Applies optional ReLU and emits the 12x12x6 pooled map to the next conv stage.
- No backpressure, matching the conv1 stream.

Parameters:
- CH, 6, number of channels processed in parallel.
- DW, 16, signed width of each channel sample (two's complement).
- IMG_W, 24, input row width in pixels; must be even.
- IMG_H, 24, input rows per frame; must be even.
- RELU, 1, 1 = clamp negative results to 0 after pooling; 0 = pass signed max.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  CH*DW  channel c at bits [c*DW +: DW], signed.
- in_valid  input  1  in_data valid this cycle; one pixel per valid beat.
- in_sof  input  1  qualified by in_valid; marks pixel (row 0, col 0) of a frame.
- out_data  output  CH*DW  pooled result, same channel packing.
- out_valid  output  1  out_data valid, single-cycle pulse per pooled pixel.
- out_sof  output  1  with out_valid, first pooled pixel of a frame.
- out_last  output  1  with out_valid, last pooled pixel of a frame (pooled row IMG_H/2-1, col IMG_W/2-1).

Behaviour:
- Reset is asynchronous on rst_n low: out_data=0, out_valid=0, out_sof=0, out_last=0, col=0, row=0, horizontal hold regs=0. Row buffer contents are don't-care.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance only on in_valid. col wraps to 0 and increments row. At (IMG_H-1, IMG_W-1) both wrap to 0; the next frame needs no sof.
- in_sof & in_valid: that beat is forced to position (0,0) regardless of counter state, and counters continue from (0,1).
  - A mid-frame sof silently abandons the partial frame.
  - No output is produced for incomplete windows.
  - Stale row-buffer entries are harmless because even rows always write before odd rows read.
  - in_sof without in_valid is ignored.
- Per-channel datapath on each valid beat, with all compares signed:
  - Even col: hold[c] <= in[c].
  - Odd col: hmax[c] = max(hold[c], in[c]) (combinational).
  - Even row, odd col: row buffer[col>>1] <= hmax (all channels in one word).
  - Odd row, odd col: res[c] = max(rowbuf[col>>1][c], hmax[c]). If RELU=1, res[c] = max(res[c], 0). Register res into out_data.
- Latency: out_valid asserts exactly 1 cycle after the in_valid beat at (odd row, odd col); otherwise 0.
  - out_data holds its last value when out_valid=0.
  - Gaps in in_valid stall the counters without losing state.
- out_sof=1 for pooled pixel (0,0), i.e. the input beat at (1,1). out_last=1 for the input beat at (IMG_H-1, IMG_W-1).
- Output count: exactly (IMG_W/2)*(IMG_H/2)=144 pulses per complete frame.
- Equal operands: max returns either; no tie rule is needed since values are identical.
- Extremes: the most negative value (-2^(DW-1)) compares correctly with no overflow, since there is no arithmetic beyond compare.

Decomposition:
- The shared cnn_defines package holds CONV1_OUT_W=24, CONV1_OUT_H=24, CONV1_CH=6, CNN_FEAT_DW=16 and POOL1_OUT_W=12, used as the parameter defaults.
- Sub-module pool_row_buffer:
  - Depth IMG_W/2, width CH*DW.
  - Synchronous write, asynchronous (distributed) read addressed by col>>1, so that the 1-cycle latency holds.
  - No reset on storage.
- The top level holds the counters, hold regs, compare tree and output regs.

Test Plan:
- Ramp: channel c pixel(r,x) = r*24 + x + c, full frame, continuous valid -> 144 out_valid pulses. Pooled (i,j) = (2i+1)*24 + 2j+1 + c. out_sof on the first pulse, out_last on the 144th, each 1 cycle after the input beats at (1,1) and (23,23).
- Negative values, RELU=0: all pixels -100 except pixel (0,0) = -3 -> pooled (0,0) = -3, others -100. With RELU=1, all outputs 0.
- Max position sweep: in each 2x2 window, place 500 at a rotating one of the four positions, others 7 -> every output = 500, confirming all four operands are used, including the row-buffer path.
- Valid gaps: ramp frame with in_valid toggling randomly, 30% idle -> identical out_data sequence to the continuous case. out_valid only follows odd/odd beats.
- Mid-frame sof: send 10 rows, then sof and a full ramp frame -> exactly 5*12 pulses from the partial frame, then 144 correct pulses with out_sof on the new frame's first pooled pixel. Back-to-back frames without sof also yield 288 correct pulses.
- Reset mid-frame: assert rst_n low for 2 cycles at row 7 -> all outputs go 0 immediately. The following full frame produces 144 correct outputs.
